// File: rtl/roll_pkg.sv
// Shared definitions for the roll result recorder and its history store.
// Contents:
//   digit_t               4-bit value produced by the roller
//   state_t               recorder FSM states
//   DEFAULT_SETTLE_CYCLES default settle time, shared with the roller's
//                         duration limits so the two stay consistent
package roll_pkg;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WATCH = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   // Must exceed the roller's longest interval between value updates.
   localparam int DEFAULT_SETTLE_CYCLES = 6_000_000;

endpackage : roll_pkg

// File: rtl/roll_result_history.sv
// Newest-first history of settled roll results.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push          insert i_data as entry 0; older entries shift down and
//                   the oldest is dropped when the store is full
//   i_clear         empty the store (wins over i_push)
//   i_data          value to insert
//   i_rd_idx        entry to read (0 = newest)
//   o_rd_data       combinational read of entry i_rd_idx
//   o_count         number of valid entries, saturates at DEPTH
module roll_result_history
   import roll_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_clear,
   input  digit_t                     i_data,
   input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
   output digit_t                     o_rd_data,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int CNT_BITS = $clog2(DEPTH) + 1;
   localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

   digit_t entries [DEPTH];

   // NOTE: the entries are reset along with the control state because a
   // cleared or freshly reset history must read back as zeros, not stale data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
         o_count <= '0;
      end else if (i_clear) begin
         for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
         o_count <= '0;
      end else if (i_push) begin
         for (int k = DEPTH - 1; k > 0; k--) entries[k] <= entries[k-1];
         entries[0] <= i_data;
         if (o_count != FULL) o_count <= o_count + 1'b1;
      end
   end

   // DEPTH is a power of two, so every index value addresses a real entry.
   assign o_rd_data = entries[i_rd_idx];

endmodule : roll_result_history

// File: rtl/roll_result_recorder.sv
// Watches the roller output after each start press, decides when the roll
// has stopped, records the result in a newest-first history and drives the
// value/index pair for the 7-segment display path.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         start key pulse (same pulse the roller receives)
//   i_value         roller output being observed
//   i_recall        step the display to the next older history entry
//   i_clear         empty the history
//   o_display       value to show
//   o_index         history slot shown (0 = newest)
//   o_count         number of valid history entries
//   o_live          roll in progress, display follows i_value
//   o_settled       one-cycle pulse when a result is committed
module roll_result_recorder
   import roll_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int CNT_W         = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [3:0]                 i_value,
   input  logic                       i_recall,
   input  logic                       i_clear,
   output logic [3:0]                 o_display,
   output logic [$clog2(DEPTH)-1:0]   o_index,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_live,
   output logic                       o_settled
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   digit_t             last_q, last_d;
   digit_t             display_d;
   logic [IDX_W-1:0]   index_d;
   logic               live_d;
   logic               settled_d;
   logic               push;
   logic               hist_clear;
   digit_t             rd_data;
   logic [IDX_W:0]     idx_plus;

   roll_result_history #(
      .DEPTH (DEPTH)
   ) u_history (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_push    (push),
      .i_clear   (hist_clear),
      .i_data    (i_value),
      .i_rd_idx  (index_d),
      .o_rd_data (rd_data),
      .o_count   (o_count)
   );

   // Recall wraps back to the newest entry after the oldest valid one.
   assign idx_plus = {1'b0, o_index} + (IDX_W + 1)'(1);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      display_d  = o_display;
      index_d    = o_index;
      live_d     = o_live;
      settled_d  = 1'b0;
      push       = 1'b0;
      hist_clear = 1'b0;

      if (i_clear) begin
         // Clear beats a simultaneous start or recall.
         hist_clear = 1'b1;
         state_d    = S_IDLE;
         index_d    = '0;
         display_d  = '0;
         live_d     = 1'b0;
      end else if (i_start) begin
         // A start mid-watch simply restarts settle timing.
         state_d   = S_WATCH;
         index_d   = '0;
         live_d    = 1'b1;
         cnt_d     = '0;
         last_d    = i_value;
         display_d = i_value;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_WATCH: begin
               display_d = i_value;
               last_d    = i_value;
               if (i_value != last_q) begin
                  cnt_d = '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  // SETTLE_CYCLES consecutive unchanged cycles: commit.
                  cnt_d     = SETTLE_MAX;
                  push      = 1'b1;
                  state_d   = S_SHOW;
                  settled_d = 1'b1;
                  live_d    = 1'b0;
                  index_d   = '0;
               end else if (cnt_q < SETTLE_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_SHOW: begin
               if (i_recall) begin
                  index_d = (idx_plus == o_count) ? '0 : idx_plus[IDX_W-1:0];
               end
               display_d = rd_data;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_q    <= '0;
         o_display <= '0;
         o_index   <= '0;
         o_live    <= 1'b0;
         o_settled <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         o_display <= display_d;
         o_index   <= index_d;
         o_live    <= live_d;
         o_settled <= settled_d;
      end
   end

endmodule : roll_result_recorder

// File: doc/roll_result_recorder.md
Name: roll_result_recorder

Overview:
- Consumer-side companion to the dice/random roller.
- Watches the roller's 4-bit output after each start press and detects when the roll has stopped.
- Stores each settled result in a newest-first history and drives a value plus index for the 7-segment display path.
- A recall key steps through past results; a clear key empties the history.

Parameters:
- DEPTH, 4, number of stored results (power of two, 2..8).
- SETTLE_CYCLES, 6000000, consecutive cycles with an unchanged input before the roll is declared settled; must exceed the roller's longest update interval.
- CNT_W, 32, settle counter width.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start key pulse, same signal fed to the roller; one cycle wide
- i_value  input  4  roller output being observed
- i_recall  input  1  one-cycle pulse; show the next older history entry
- i_clear  input  1  one-cycle pulse; empty the history
- o_display  output  4  value to display
- o_index  output  $clog2(DEPTH)  history slot shown (0 = newest)
- o_count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- o_live  output  1  high while the roll is in progress (display follows i_value)
- o_settled  output  1  one-cycle pulse when a result is committed

Behaviour:
- Reset (async): state S_IDLE; o_display=0, o_index=0, o_count=0, o_live=0, o_settled=0; history entries=0; settle counter=0; last-value register=0.
- All outputs are registered.
- States: S_IDLE, S_WATCH, S_SHOW.
- Priority in every state: i_clear, then i_start, then i_recall.
- i_clear (any state):
  - o_count=0, all entries=0, o_index=0, o_display=0, o_live=0.
  - Next state S_IDLE.
  - A simultaneous i_start is ignored.
- i_start (any state, no clear):
  - Next state S_WATCH; o_index=0; o_live=1.
  - Settle counter=0; last-value register=i_value.
  - i_start during S_WATCH restarts settle timing and commits nothing.
- S_IDLE: o_display holds its value; i_recall is ignored.
- S_WATCH:
  - o_display follows i_value with 1-cycle latency.
  - Each cycle: if i_value != last value, the counter clears to 0; otherwise it increments, saturating at SETTLE_CYCLES.
  - Last value updates every cycle.
  - When the counter reaches SETTLE_CYCLES-1 with i_value unchanged, commit next cycle:
    - Shift history (entry k -> k+1; the oldest drops when full).
    - entry0=i_value.
    - o_count=min(o_count+1, DEPTH).
    - o_settled pulses for 1 cycle, in the same cycle state becomes S_SHOW.
    - o_live=0; o_index=0; o_display=entry0.
  - i_recall is ignored.
- S_SHOW:
  - o_display = entry[o_index].
  - i_recall sets o_index = (o_index+1 == o_count) ? 0 : o_index+1.
  - With o_count=1, o_index stays 0.
  - i_recall and i_clear in the same cycle: clear wins.
- A result equal to the previous roll is still committed as a new entry.
- Values changing only after SETTLE_CYCLES are treated as a new roll only if a new i_start arrives.
- Width rules: settle counter is CNT_W bits unsigned, compared against SETTLE_CYCLES-1; o_count saturates and never wraps.
- Reset mid-watch: no commit; history is lost.

Decomposition:
- Shared package (e.g. roll_pkg):
  - state enum {S_IDLE, S_WATCH, S_SHOW}
  - digit type logic [3:0]
  - default SETTLE_CYCLES constant, shared with the roller's duration limits
- Sub-module: roll_history (DEPTH-entry shift-register store with push, clear, count, and read-by-index).
- FSM and settle counter stay in the top.

Test Plan (SETTLE_CYCLES=8, DEPTH=4):
1. Reset then idle 20 cycles -> all outputs 0, state S_IDLE; i_recall pulses cause no change.
2. i_start; i_value changes every 3 cycles for 30 cycles, then holds 4'h9 -> o_live=1 throughout; o_settled pulses exactly 8 cycles after the last change; o_display=9, o_count=1, o_index=0, o_live=0.
3. Five rolls settling on 3,7,7,A,5 -> o_count=4; recall sequence shows 5,A,7,7,5 with o_index 0,1,2,3,0.
4. i_start during S_WATCH at counter=6 while holding 2, then hold 2 -> no commit until 8 unchanged cycles after the restart; single o_settled pulse.
5. i_clear and i_start asserted in the same cycle in S_SHOW -> state S_IDLE, o_count=0, o_display=0, o_live=0.
6. Deassert i_rst_n mid-S_WATCH -> outputs 0 immediately (asynchronous); no o_settled pulse after release.
